// File: rtl/or_gate_exerciser_pkg.sv
// rtl/or_gate_exerciser_pkg.sv - shared types and helpers for the OR gate exerciser
package or_gate_exerciser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Bits needed to hold the value v without wrap.
    function automatic int cnt_width(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v + 1);
    endfunction

    // Golden model of the gate under test; callers zero-extend narrower vectors.
    function automatic logic golden_or(input logic [7:0] v);
        return |v;
    endfunction

endpackage

// File: rtl/or_gate_exerciser_settle_timer.sv
// rtl/or_gate_exerciser_settle_timer.sv - loadable down-counter timing the settle window
module settle_timer
    import or_gate_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = cnt_width(SETTLE_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(SETTLE_CYCLES);
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Expiry on the last held cycle gives exactly SETTLE_CYCLES cycles in SETTLE.
    assign expire = (count == W'(1));

endmodule

// File: rtl/or_gate_exerciser.sv
// rtl/or_gate_exerciser.sv - sweeps every input vector of an OR gate and scores the results
module or_gate_exerciser
    import or_gate_exerciser_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_INPUTS-1:0] drive,
    input  logic                gate_out,
    output logic                busy,
    output logic                done,
    output logic                mismatch,
    output logic [N_INPUTS-1:0] mismatch_vec,
    output logic [N_INPUTS:0]   pass_count,
    output logic [N_INPUTS:0]   fail_count
);

    localparam logic [N_INPUTS:0]   ONE_CNT = (N_INPUTS + 1)'(1);
    localparam logic [N_INPUTS-1:0] ONE_VEC = N_INPUTS'(1);

    state_t              state;
    state_t              state_next;
    logic [N_INPUTS-1:0] vec;
    logic                expire;
    logic                go;
    logic                expected;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (state == DRIVE),
        .en    (state == SETTLE),
        .expire(expire)
    );

    assign go       = start && (state == IDLE || state == DONE);
    assign expected = golden_or(8'(vec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   state_next = SETTLE;
            SETTLE:  if (expire) state_next = CHECK;
            CHECK:   state_next = (&vec) ? DONE : DRIVE;
            DONE:    if (start) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        drive = '0;
        case (state)
            DRIVE, SETTLE, CHECK: begin
                busy  = 1'b1;
                drive = vec;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Scoreboard; mismatch is cleared every cycle so it only pulses after a failing CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec          <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
            mismatch     <= 1'b0;
            mismatch_vec <= '0;
        end else begin
            mismatch <= 1'b0;
            if (go) begin
                vec        <= '0;
                pass_count <= '0;
                fail_count <= '0;
            end else if (state == CHECK) begin
                if (gate_out == expected) begin
                    pass_count <= pass_count + ONE_CNT;
                end else begin
                    fail_count   <= fail_count + ONE_CNT;
                    mismatch     <= 1'b1;
                    mismatch_vec <= vec;
                end
                if (!(&vec)) begin
                    vec <= vec + ONE_VEC;
                end
            end
        end
    end

endmodule

// File: tb/tb_or_gate_exerciser.sv
// tb/tb_or_gate_exerciser.sv - directed self-checking bench for or_gate_exerciser
module tb_or_gate_exerciser;
    import or_gate_exerciser_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         gate_mode = 0;

    logic       start_a = 1'b0;
    logic [1:0] drive_a;
    logic       gate_out_a;
    logic       busy_a, done_a, mismatch_a;
    logic [1:0] mismatch_vec_a;
    logic [2:0] pass_a, fail_a;

    logic       start_b = 1'b0;
    logic [2:0] drive_b;
    logic       gate_out_b;
    logic       busy_b, done_b, mismatch_b;
    logic [2:0] mismatch_vec_b;
    logic [3:0] pass_b, fail_b;

    int checks = 0;
    int failures = 0;
    logic [7:0] drv_hist [0:255];

    always #5 clk = ~clk;

    // 0: real OR, 1: output stuck at 0, 2: AND gate substituted
    always_comb begin
        case (gate_mode)
            1:       gate_out_a = 1'b0;
            2:       gate_out_a = &drive_a;
            default: gate_out_a = |drive_a;
        endcase
    end
    assign gate_out_b = |drive_b;

    or_gate_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .drive(drive_a), .gate_out(gate_out_a),
        .busy(busy_a), .done(done_a), .mismatch(mismatch_a), .mismatch_vec(mismatch_vec_a),
        .pass_count(pass_a), .fail_count(fail_a)
    );

    or_gate_exerciser #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .drive(drive_b), .gate_out(gate_out_b),
        .busy(busy_b), .done(done_b), .mismatch(mismatch_b), .mismatch_vec(mismatch_vec_b),
        .pass_count(pass_b), .fail_count(fail_b)
    );

    // k=0 is the sample just after the start edge; returns -1 if done never rose.
    task automatic sweep(input int sel, input int restart_at, input int stop_at,
                         output int done_k, output int pulses);
        pulses = 0;
        done_k = -1;
        if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            drv_hist[k] = (sel == 1) ? 8'(drive_b) : 8'(drive_a);
            pulses += (sel == 1) ? int'(mismatch_b) : int'(mismatch_a);
            if (k == restart_at) start_a = 1'b1;
            if (k == stop_at) break;
            if (((sel == 1) ? done_b : done_a) === 1'b1) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy_a, done_a, mismatch_a, drive_a, mismatch_vec_a, pass_a, fail_a} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b mis=%b drv=%0d mv=%0d p=%0d f=%0d want all 0",
                     busy_a, done_a, mismatch_a, drive_a, mismatch_vec_a, pass_a, fail_a);
        end
        checks++;
        if (dut_a.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d want IDLE", dut_a.state);
        end
    endtask

    task automatic test_real_or;
        int dk, pl;
        gate_mode = 0;
        sweep(0, -1, -1, dk, pl);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (drv_hist[k] !== 8'(k / 4)) begin
                failures++;
                $display("FAIL real_or_drive k=%0d got %0d want %0d", k, drv_hist[k], k / 4);
            end
        end
        checks++;
        if (dk !== 16) begin
            failures++;
            $display("FAIL real_or_done_latency got %0d want 16", dk);
        end
        checks++;
        if (pass_a !== 3'd4 || fail_a !== 3'd0 || pl !== 0) begin
            failures++;
            $display("FAIL real_or_counts got p=%0d f=%0d pulses=%0d want p=4 f=0 pulses=0", pass_a, fail_a, pl);
        end
        checks++;
        if (drive_a !== 2'd0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL real_or_done_idle got drv=%0d busy=%b want 0 0", drive_a, busy_a);
        end
    endtask

    task automatic test_stuck_zero;
        int dk, pl;
        gate_mode = 1;
        sweep(0, -1, -1, dk, pl);
        checks++;
        if (dk !== 16 || pass_a !== 3'd1 || fail_a !== 3'd3 || pl !== 3 || mismatch_vec_a !== 2'b11) begin
            failures++;
            $display("FAIL stuck_zero got done_k=%0d p=%0d f=%0d pulses=%0d mv=%b want 16 1 3 3 11",
                     dk, pass_a, fail_a, pl, mismatch_vec_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mismatch_a !== 1'b0 || done_a !== 1'b1 || fail_a !== 3'd3) begin
            failures++;
            $display("FAIL stuck_zero_hold got mis=%b done=%b f=%0d want 0 1 3", mismatch_a, done_a, fail_a);
        end
    endtask

    task automatic test_and_gate;
        int dk, pl;
        gate_mode = 2;
        sweep(0, -1, -1, dk, pl);
        checks++;
        if (dk !== 16 || pass_a !== 3'd2 || fail_a !== 3'd2 || pl !== 2 || mismatch_vec_a !== 2'b10) begin
            failures++;
            $display("FAIL and_gate got done_k=%0d p=%0d f=%0d pulses=%0d mv=%b want 16 2 2 2 10",
                     dk, pass_a, fail_a, pl, mismatch_vec_a);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int dk, pl;
        gate_mode = 0;
        sweep(0, -1, 9, dk, pl);
        checks++;
        if (drive_a !== 2'd2 || dut_a.state !== SETTLE || pass_a !== 3'd2) begin
            failures++;
            $display("FAIL mid_sweep_pre got drv=%0d state=%0d p=%0d want 2 SETTLE 2", drive_a, dut_a.state, pass_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, mismatch_a, drive_a, mismatch_vec_a, pass_a, fail_a} !== '0 || dut_a.state !== IDLE) begin
            failures++;
            $display("FAIL mid_sweep_reset got busy=%b drv=%0d p=%0d state=%0d want 0 0 0 IDLE",
                     busy_a, drive_a, pass_a, dut_a.state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mismatch_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_sweep_quiet got mis=%b busy=%b want 0 0", mismatch_a, busy_a);
        end
        sweep(0, -1, -1, dk, pl);
        checks++;
        if (dk !== 16 || pass_a !== 3'd4 || fail_a !== 3'd0) begin
            failures++;
            $display("FAIL mid_sweep_fresh got done_k=%0d p=%0d f=%0d want 16 4 0", dk, pass_a, fail_a);
        end
    endtask

    task automatic test_back_to_back;
        int dk, pl;
        gate_mode = 0;
        sweep(0, 5, -1, dk, pl);
        checks++;
        if (dk !== 16 || pass_a !== 3'd4 || fail_a !== 3'd0 || drv_hist[6] !== 8'd1 || drv_hist[8] !== 8'd2) begin
            failures++;
            $display("FAIL busy_restart got done_k=%0d p=%0d f=%0d d6=%0d d8=%0d want 16 4 0 1 2",
                     dk, pass_a, fail_a, drv_hist[6], drv_hist[8]);
        end
    endtask

    task automatic test_n3_settle1;
        int dk, pl;
        sweep(1, -1, -1, dk, pl);
        checks++;
        if (dk !== 24 || pass_b !== 4'd8 || fail_b !== 4'd0 || pl !== 0) begin
            failures++;
            $display("FAIL n3_settle1 got done_k=%0d p=%0d f=%0d pulses=%0d want 24 8 0 0", dk, pass_b, fail_b, pl);
        end
        for (int v = 0; v < 8; v++) begin
            checks++;
            if (drv_hist[v * 3] !== 8'(v) || drv_hist[v * 3 + 2] !== 8'(v)) begin
                failures++;
                $display("FAIL n3_drive v=%0d got %0d,%0d want %0d", v, drv_hist[v * 3], drv_hist[v * 3 + 2], v);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_real_or;
        test_stuck_zero;
        test_and_gate;
        test_reset_mid_sweep;
        test_back_to_back;
        test_n3_settle1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
